// File: rtl/lcd_text_console.sv
// lcd_text_console: turns an ASCII byte stream into lcd_rgb screen-memory writes,
// keeps a character cursor, and handles CR, LF, BS and FF.
module lcd_text_console #(
  parameter int         COLUMNS        = 60,
  parameter int         ROWS           = 17,
  parameter logic [7:0] CHAR_OFFSET    = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        bus_select,
  output logic [3:0]  bus_wstrb,
  output logic [9:0]  bus_addr,
  output logic [31:0] bus_data,
  input  logic        bus_ready,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam logic [9:0]  COLS_W     = 10'(COLUMNS);
  localparam logic [9:0]  LAST_WORD  = 10'(ROWS * COLUMNS - 4);
  localparam logic [9:0]  ROW_SPAN   = 10'(COLUMNS - 4);
  localparam logic [5:0]  COL_MAX    = 6'(COLUMNS - 1);
  localparam logic [4:0]  ROW_MAX    = 5'(ROWS - 1);
  localparam logic [7:0]  BLANK      = 8'h20 - CHAR_OFFSET;
  localparam logic [31:0] BLANK_WORD = {4{BLANK}};

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  // IDLE waits for a byte, WR holds a request, GAP idles the bus for one cycle,
  // CLR latches the first word of a clear before handing over to WR/GAP.
  typedef enum logic [1:0] {IDLE, WR, GAP, CLR} state_t;

  state_t      state, state_nxt;
  logic        clr_active, clr_active_nxt;
  logic        clr_full, clr_full_nxt;
  logic        adv_pending, adv_pending_nxt;
  logic [9:0]  clr_start, clr_start_nxt;
  logic [9:0]  clr_last, clr_last_nxt;
  logic        bus_select_nxt;
  logic [3:0]  bus_wstrb_nxt;
  logic [9:0]  bus_addr_nxt;
  logic [31:0] bus_data_nxt;
  logic [5:0]  col_nxt;
  logic [4:0]  row_nxt;
  logic        in_ready_nxt;
  logic        busy_nxt;

  logic        accept;
  logic        is_print;
  logic [9:0]  cell_off;
  logic [4:0]  row_adv;
  logic [9:0]  row_adv_base;
  logic [7:0]  glyph;
  logic        clr_done;

  // Byte decode and cursor-derived addresses used by the control logic.
  always_comb begin
    accept       = in_valid && (state == IDLE);
    is_print     = (in_data >= 8'h20) && (in_data <= 8'h7E);
    cell_off     = 10'(cursor_row) * COLS_W + 10'(cursor_col);
    row_adv      = (cursor_row == ROW_MAX) ? 5'd0 : cursor_row + 5'd1;
    row_adv_base = 10'(row_adv) * COLS_W;
    glyph        = {1'b0, 7'(in_data - CHAR_OFFSET)};
    clr_done     = (bus_addr == clr_last);
  end

  // State register plus every registered output; reset abandons any job.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR_ON_RESET ? CLR : IDLE;
      clr_active  <= CLEAR_ON_RESET;
      clr_full    <= 1'b1;
      adv_pending <= 1'b0;
      clr_start   <= 10'd0;
      clr_last    <= LAST_WORD;
      bus_select  <= 1'b0;
      bus_wstrb   <= 4'd0;
      bus_addr    <= 10'd0;
      bus_data    <= 32'd0;
      cursor_col  <= 6'd0;
      cursor_row  <= 5'd0;
      in_ready    <= !CLEAR_ON_RESET;
      busy        <= CLEAR_ON_RESET;
    end else begin
      state       <= state_nxt;
      clr_active  <= clr_active_nxt;
      clr_full    <= clr_full_nxt;
      adv_pending <= adv_pending_nxt;
      clr_start   <= clr_start_nxt;
      clr_last    <= clr_last_nxt;
      bus_select  <= bus_select_nxt;
      bus_wstrb   <= bus_wstrb_nxt;
      bus_addr    <= bus_addr_nxt;
      bus_data    <= bus_data_nxt;
      cursor_col  <= col_nxt;
      cursor_row  <= row_nxt;
      in_ready    <= in_ready_nxt;
      busy        <= busy_nxt;
    end
  end

  // Next-state decision: printable bytes write, LF/FF clear, the rest stay idle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_print) begin
            state_nxt = WR;
          end else if ((in_data == CH_LF) || (in_data == CH_FF)) begin
            state_nxt = CLR;
          end
        end
      end
      WR: begin
        if (bus_ready) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (clr_active) begin
          state_nxt = clr_done ? IDLE : WR;
        end else begin
          state_nxt = adv_pending ? CLR : IDLE;
        end
      end
      CLR: begin
        state_nxt = WR;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output and datapath values to be registered on the next edge.
  always_comb begin
    clr_active_nxt  = clr_active;
    clr_full_nxt    = clr_full;
    adv_pending_nxt = adv_pending;
    clr_start_nxt   = clr_start;
    clr_last_nxt    = clr_last;
    bus_wstrb_nxt   = bus_wstrb;
    bus_addr_nxt    = bus_addr;
    bus_data_nxt    = bus_data;
    col_nxt         = cursor_col;
    row_nxt         = cursor_row;

    case (state)
      IDLE: begin
        if (accept) begin
          if (is_print) begin
            bus_addr_nxt    = cell_off;
            bus_wstrb_nxt   = 4'b0001 << cell_off[1:0];
            bus_data_nxt    = 32'(glyph) << {cell_off[1:0], 3'b000};
            adv_pending_nxt = (cursor_col == COL_MAX);
            clr_active_nxt  = 1'b0;
          end else begin
            case (in_data)
              CH_CR: begin
                col_nxt = 6'd0;
              end
              CH_BS: begin
                if (cursor_col != 6'd0) begin
                  col_nxt = cursor_col - 6'd1;
                end
              end
              CH_LF: begin
                col_nxt         = 6'd0;
                row_nxt         = row_adv;
                clr_start_nxt   = row_adv_base;
                clr_last_nxt    = row_adv_base + ROW_SPAN;
                clr_full_nxt    = 1'b0;
                clr_active_nxt  = 1'b1;
                adv_pending_nxt = 1'b0;
              end
              CH_FF: begin
                clr_start_nxt   = 10'd0;
                clr_last_nxt    = LAST_WORD;
                clr_full_nxt    = 1'b1;
                clr_active_nxt  = 1'b1;
                adv_pending_nxt = 1'b0;
              end
              default: begin
              end
            endcase
          end
        end
      end
      GAP: begin
        if (clr_active) begin
          if (!clr_done) begin
            bus_addr_nxt = bus_addr + 10'd4;
          end else begin
            clr_active_nxt = 1'b0;
            if (clr_full) begin
              col_nxt = 6'd0;
              row_nxt = 5'd0;
            end
          end
        end else if (adv_pending) begin
          col_nxt         = 6'd0;
          row_nxt         = row_adv;
          clr_start_nxt   = row_adv_base;
          clr_last_nxt    = row_adv_base + ROW_SPAN;
          clr_full_nxt    = 1'b0;
          clr_active_nxt  = 1'b1;
          adv_pending_nxt = 1'b0;
        end else begin
          col_nxt = cursor_col + 6'd1;
        end
      end
      CLR: begin
        bus_addr_nxt  = clr_start;
        bus_wstrb_nxt = 4'hF;
        bus_data_nxt  = BLANK_WORD;
      end
      default: begin
      end
    endcase

    bus_select_nxt = (state_nxt == WR);
    in_ready_nxt   = (state_nxt == IDLE);
    busy_nxt       = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_lcd_text_console.sv
// tb_lcd_text_console: directed scenarios plus randomized text checked against a
// screen/cursor model, with a registered-ready slave that can be stalled.
module tb_lcd_text_console;

  localparam int COLUMNS = 60;
  localparam int ROWS    = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        bus_select;
  logic [3:0]  bus_wstrb;
  logic [9:0]  bus_addr;
  logic [31:0] bus_data;
  logic        bus_ready = 1'b0;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  logic stall = 1'b0;
  logic rand_stall = 1'b0;
  logic rand_stall_en = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int select_cycles = 0;

  typedef struct packed {
    logic [9:0]  addr;
    logic [3:0]  wstrb;
    logic [31:0] data;
  } wr_t;

  wr_t        wlog[$];
  logic [7:0] mem [0:1023];
  logic [7:0] scr [0:ROWS*COLUMNS-1];

  lcd_text_console #(
    .COLUMNS(COLUMNS),
    .ROWS(ROWS),
    .CHAR_OFFSET(8'h20),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .bus_select(bus_select),
    .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr),
    .bus_data(bus_data),
    .bus_ready(bus_ready),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave with registered ready, like lcd_rgb; stall holds ready low.
  always @(posedge clk) begin
    if (rst) bus_ready <= 1'b0;
    else     bus_ready <= bus_select && !stall && !rand_stall;
  end

  always @(negedge clk) begin
    rand_stall = rand_stall_en && ($urandom_range(0, 3) == 0);
  end

  // Bus monitor: logs each completed write and applies it to a byte memory.
  always @(negedge clk) begin
    int base;
    if (bus_select) select_cycles++;
    if (!rst && bus_select && bus_ready) begin
      wlog.push_back({bus_addr, bus_wstrb, bus_data});
      base = int'({bus_addr[9:2], 2'b00});
      for (int i = 0; i < 4; i++) begin
        if (bus_wstrb[i]) mem[base + i] = bus_data[8*i +: 8];
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout byte %02h in_ready=%0b want 1", b, in_ready);
      in_valid = 1'b0;
      acc_cyc = cyc;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    @(negedge clk);
    while (!(in_ready && !busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!(in_ready && !busy)) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL idle_timeout in_ready=%0b busy=%0b want 1/0", in_ready, busy);
    end
  endtask

  task automatic put(input logic [7:0] b);
    int t;
    send_byte(b, t);
    wait_idle(3000);
  endtask

  task automatic check_clear_log(input string name, input int count, input int first_addr);
    int bad = 0;
    wr_t exp;
    compared++;
    if (wlog.size() != count) begin
      mismatched++;
      $display("[TB] FAIL %s_count got %0d want %0d", name, wlog.size(), count);
    end
    for (int k = 0; k < count; k++) begin
      exp = {10'(first_addr + 4*k), 4'hF, 32'h0};
      if (k >= wlog.size() || wlog[k] !== exp) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("[TB] FAIL %s_words got %0d wrong words want 0", name, bad);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({bus_select, bus_wstrb, bus_addr, bus_data} !== 47'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_bus got sel=%0b strb=%h addr=%0d data=%h want all 0",
               bus_select, bus_wstrb, bus_addr, bus_data);
    end
    compared++;
    if ({cursor_col, cursor_row} !== 11'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_cursor got (%0d,%0d) want (0,0)", cursor_col, cursor_row);
    end
    compared++;
    if ({in_ready, busy} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL reset_flags got in_ready=%0b busy=%0b want 0/1", in_ready, busy);
    end
    wlog.delete();
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (bus_select !== 1'b1 || bus_addr !== 10'd0) begin
      mismatched++;
      $display("[TB] FAIL clear_start got sel=%0b addr=%0d want 1/0", bus_select, bus_addr);
    end
    wait_idle(3000);
    check_clear_log("reset_clear", 255, 0);
    compared++;
    if ({cursor_col, cursor_row, in_ready} !== 12'd1) begin
      mismatched++;
      $display("[TB] FAIL reset_done got (%0d,%0d) in_ready=%0b want (0,0) 1",
               cursor_col, cursor_row, in_ready);
    end
    for (int i = 0; i < ROWS*COLUMNS; i++) if (mem[i] !== 8'h00) bad++;
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("[TB] FAIL reset_mem got %0d dirty bytes want 0", bad);
    end
  endtask

  task automatic test_print();
    int t;
    int lat = -1;
    wr_t got;
    repeat (5) put(8'h20);
    wlog.delete();
    send_byte(8'h41, t);
    @(negedge clk);
    compared++;
    if (bus_select !== 1'b1 || bus_addr !== 10'd5) begin
      mismatched++;
      $display("[TB] FAIL print_select got sel=%0b addr=%0d want 1/5", bus_select, bus_addr);
    end
    for (int n = 0; n < 20 && lat < 0; n++) begin
      if (in_ready) lat = cyc - t;
      else @(negedge clk);
    end
    // in_ready is back in cycle T+4, i.e. after the third edge following acceptance.
    compared++;
    if (lat != 3) begin
      mismatched++;
      $display("[TB] FAIL print_latency got %0d edges want 3", lat);
    end
    wait_idle(100);
    got = (wlog.size() > 0) ? wlog[0] : '0;
    compared++;
    if (wlog.size() != 1 || got !== {10'd5, 4'b0010, 32'h00002100}) begin
      mismatched++;
      $display("[TB] FAIL print_write got n=%0d addr=%0d strb=%b data=%h want 1/5/0010/00002100",
               wlog.size(), got.addr, got.wstrb, got.data);
    end
    compared++;
    if (cursor_col !== 6'd6 || cursor_row !== 5'd0) begin
      mismatched++;
      $display("[TB] FAIL print_cursor got (%0d,%0d) want (6,0)", cursor_col, cursor_row);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    wr_t got;
    wr_t exp;
    put(8'h0C);
    repeat (16) put(8'h0A);
    repeat (59) put(8'h20);
    compared++;
    if (cursor_col !== 6'd59 || cursor_row !== 5'd16) begin
      mismatched++;
      $display("[TB] FAIL wrap_setup got (%0d,%0d) want (59,16)", cursor_col, cursor_row);
    end
    wlog.delete();
    put(8'h5A);
    got = (wlog.size() > 0) ? wlog[0] : '0;
    compared++;
    if (got !== {10'd1019, 4'b1000, 32'h3A000000}) begin
      mismatched++;
      $display("[TB] FAIL wrap_char got addr=%0d strb=%b data=%h want 1019/1000/3a000000",
               got.addr, got.wstrb, got.data);
    end
    compared++;
    if (wlog.size() != 16) begin
      mismatched++;
      $display("[TB] FAIL wrap_count got %0d want 16", wlog.size());
    end
    for (int k = 1; k < 16; k++) begin
      exp = {10'(4*(k-1)), 4'hF, 32'h0};
      if (k >= wlog.size() || wlog[k] !== exp) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("[TB] FAIL wrap_rowclear got %0d wrong words want 0", bad);
    end
    compared++;
    if (cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
      mismatched++;
      $display("[TB] FAIL wrap_cursor got (%0d,%0d) want (0,0)", cursor_col, cursor_row);
    end
  endtask

  task automatic test_lf_cr();
    int sc;
    put(8'h0C);
    repeat (3) put(8'h0A);
    repeat (10) put(8'h20);
    wlog.delete();
    put(8'h0A);
    compared++;
    if (cursor_col !== 6'd0 || cursor_row !== 5'd4) begin
      mismatched++;
      $display("[TB] FAIL lf_cursor got (%0d,%0d) want (0,4)", cursor_col, cursor_row);
    end
    check_clear_log("lf_clear", 15, 240);
    repeat (3) put(8'h20);
    sc = select_cycles;
    put(8'h0D);
    repeat (3) @(negedge clk);
    compared++;
    if (select_cycles != sc) begin
      mismatched++;
      $display("[TB] FAIL cr_bus got %0d select cycles want 0", select_cycles - sc);
    end
    compared++;
    if (cursor_col !== 6'd0 || cursor_row !== 5'd4) begin
      mismatched++;
      $display("[TB] FAIL cr_cursor got (%0d,%0d) want (0,4)", cursor_col, cursor_row);
    end
  endtask

  task automatic test_bs_junk();
    int sc;
    sc = select_cycles;
    put(8'h08);
    compared++;
    if (cursor_col !== 6'd0 || cursor_row !== 5'd4 || select_cycles != sc) begin
      mismatched++;
      $display("[TB] FAIL bs_col0 got (%0d,%0d) sel=%0d want (0,4) 0",
               cursor_col, cursor_row, select_cycles - sc);
    end
    repeat (7) put(8'h20);
    put(8'h08);
    compared++;
    if (cursor_col !== 6'd6 || cursor_row !== 5'd4) begin
      mismatched++;
      $display("[TB] FAIL bs_col7 got (%0d,%0d) want (6,4)", cursor_col, cursor_row);
    end
    sc = select_cycles;
    put(8'h01);
    repeat (3) @(negedge clk);
    compared++;
    if (cursor_col !== 6'd6 || select_cycles != sc) begin
      mismatched++;
      $display("[TB] FAIL junk_byte got col=%0d sel=%0d want 6 0", cursor_col, select_cycles - sc);
    end
  endtask

  task automatic test_stall_reset();
    int t;
    int n = 0;
    int stall_bad = 0;
    bit ready_seen = 1'b0;
    logic [9:0] a0;
    send_byte(8'h0C, t);
    in_valid = 1'b1;
    in_data  = 8'h51;
    while (wlog.size() < 10 && n < 200) begin
      @(negedge clk);
      if (in_ready) ready_seen = 1'b1;
      n++;
    end
    n = 0;
    while (!(bus_select && !bus_ready) && n < 20) begin
      @(negedge clk);
      if (in_ready) ready_seen = 1'b1;
      n++;
    end
    stall = 1'b1;
    a0 = bus_addr;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (in_ready) ready_seen = 1'b1;
      if (bus_select !== 1'b1 || bus_addr !== a0 || bus_ready !== 1'b0) stall_bad++;
    end
    stall = 1'b0;
    compared++;
    if (stall_bad != 0) begin
      mismatched++;
      $display("[TB] FAIL stall_hold got %0d unstable cycles at addr %0d want 0", stall_bad, a0);
    end
    n = 0;
    while (wlog.size() < 20 && n < 200) begin
      @(negedge clk);
      if (in_ready) ready_seen = 1'b1;
      n++;
    end
    compared++;
    if (ready_seen) begin
      mismatched++;
      $display("[TB] FAIL clear_in_ready got 1 during clear want 0");
    end
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (bus_select !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_drop got sel=%0b want 0", bus_select);
    end
    wlog.delete();
    rst = 1'b0;
    wait_idle(3000);
    check_clear_log("restart_clear", 255, 0);
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    int mcol = 0;
    int mrow = 0;
    int bad;
    int first;
    rand_stall_en = 1'b1;
    put(8'h0C);
    for (int i = 0; i < ROWS*COLUMNS; i++) scr[i] = 8'h00;
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      b = 8'($urandom_range(32, 126));
      else if (r < 78) b = 8'h0A;
      else if (r < 84) b = 8'h0D;
      else if (r < 91) b = 8'h08;
      else if (r < 93) b = 8'h0C;
      else begin
        b = 8'($urandom_range(0, 255));
        if ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D)
          b = 8'h7F;
      end
      if (b >= 8'h20 && b <= 8'h7E) begin
        scr[mrow*COLUMNS + mcol] = b - 8'h20;
        if (mcol == COLUMNS-1) begin
          mcol = 0;
          mrow = (mrow + 1) % ROWS;
          for (int c = 0; c < COLUMNS; c++) scr[mrow*COLUMNS + c] = 8'h00;
        end else begin
          mcol++;
        end
      end else if (b == 8'h0D) begin
        mcol = 0;
      end else if (b == 8'h0A) begin
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
        for (int c = 0; c < COLUMNS; c++) scr[mrow*COLUMNS + c] = 8'h00;
      end else if (b == 8'h08) begin
        if (mcol > 0) mcol--;
      end else if (b == 8'h0C) begin
        for (int i = 0; i < ROWS*COLUMNS; i++) scr[i] = 8'h00;
        mcol = 0;
        mrow = 0;
      end
      put(b);
      compared++;
      if (cursor_col !== 6'(mcol) || cursor_row !== 5'(mrow)) begin
        mismatched++;
        $display("[TB] FAIL rand_cursor byte %02h got (%0d,%0d) want (%0d,%0d)",
                 b, cursor_col, cursor_row, mcol, mrow);
      end
    end
    rand_stall_en = 1'b0;
    for (int row = 0; row < ROWS; row++) begin
      bad = 0;
      first = -1;
      for (int c = 0; c < COLUMNS; c++) begin
        if (mem[row*COLUMNS + c] !== scr[row*COLUMNS + c]) begin
          bad++;
          if (first < 0) first = c;
        end
      end
      compared++;
      if (bad != 0) begin
        mismatched++;
        $display("[TB] FAIL rand_row%0d got %02h at col %0d want %02h (%0d bad)", row,
                 mem[row*COLUMNS + first], first, scr[row*COLUMNS + first], bad);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'hAA;
    test_reset();
    test_print();
    test_wrap();
    test_lf_cr();
    test_bs_junk();
    test_stall_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog got no finish by cycle %0d want finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
